// File: rtl/sparse_mac_pkg.sv
// Shared types and widths for the sparse MAC encoder/decoder path.
// The record layout here is the SRAM word format both sides agree on.
package sparse_mac_pkg;

  localparam int unsigned VALUE_W  = 8;
  localparam int unsigned SKIP_W   = 4;
  localparam int unsigned SKIP_MAX = (1 << SKIP_W) - 1;

  typedef struct packed {
    logic [SKIP_W-1:0]  skip;
    logic [VALUE_W-1:0] value;
    logic               done;
  } sram_data_t;

endpackage : sparse_mac_pkg

// File: rtl/sparse_encoder.sv
// Run-length encoder: dense element stream -> (skip, value, done) records.
// One registered output stage; each record carries the zeros preceding its value.
module sparse_encoder
  import sparse_mac_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               mac_clk,
  input  logic               mac_rst,
  input  logic               dense_valid_i,
  output logic               dense_ready_o,
  input  logic [VALUE_W-1:0] dense_value_i,
  input  logic               dense_last_i,
  output logic               enc_valid_o,
  input  logic               enc_ready_i,
  output sram_data_t         enc_data_o,
  output logic [CNT_W-1:0]   nnz_cnt_o,
  output logic               vec_done_o
);

  localparam logic [CNT_W-1:0]  NNZ_MAX  = {CNT_W{1'b1}};
  localparam logic [SKIP_W-1:0] RUN_FULL = SKIP_W'(SKIP_MAX);

  logic [SKIP_W-1:0] run_cnt_q, run_cnt_d;
  logic              enc_valid_q, enc_valid_d;
  sram_data_t        enc_data_q, enc_data_d;
  logic [CNT_W-1:0]  nnz_acc_q, nnz_acc_d;
  logic [CNT_W-1:0]  rec_nnz_q, rec_nnz_d;
  logic [CNT_W-1:0]  nnz_cnt_q, nnz_cnt_d;
  logic              vec_done_q, vec_done_d;

  logic accept, emit, is_nz, load;
  logic [CNT_W-1:0] nnz_inc;

  assign dense_ready_o = ~enc_valid_q | enc_ready_i;
  assign accept        = dense_valid_i & dense_ready_o;
  assign emit          = enc_valid_q & enc_ready_i;
  assign is_nz         = (dense_value_i != '0);
  // A record is produced for a nonzero, a vector end, or a full zero run.
  assign load          = accept & (is_nz | dense_last_i | (run_cnt_q == RUN_FULL));
  assign nnz_inc       = (is_nz && nnz_acc_q != NNZ_MAX) ? nnz_acc_q + CNT_W'(1) : nnz_acc_q;

  always_comb begin
    run_cnt_d   = run_cnt_q;
    enc_valid_d = enc_valid_q;
    enc_data_d  = enc_data_q;
    nnz_acc_d   = nnz_acc_q;
    rec_nnz_d   = rec_nnz_q;
    nnz_cnt_d   = nnz_cnt_q;
    vec_done_d  = 1'b0;

    if (emit) begin
      enc_valid_d = 1'b0;
      if (enc_data_q.done) begin
        nnz_cnt_d  = rec_nnz_q;
        vec_done_d = 1'b1;
      end
    end

    if (accept) begin
      if (load) begin
        enc_valid_d = 1'b1;
        enc_data_d  = '{skip: run_cnt_q, value: dense_value_i, done: dense_last_i};
        run_cnt_d   = '0;
      end else begin
        run_cnt_d   = run_cnt_q + SKIP_W'(1);
      end
      // Completed count travels with the done record; accumulator restarts.
      if (dense_last_i) begin
        rec_nnz_d = nnz_inc;
        nnz_acc_d = '0;
      end else begin
        nnz_acc_d = nnz_inc;
      end
    end
  end

  always_ff @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) begin
      run_cnt_q   <= '0;
      enc_valid_q <= 1'b0;
      enc_data_q  <= '0;
      nnz_acc_q   <= '0;
      rec_nnz_q   <= '0;
      nnz_cnt_q   <= '0;
      vec_done_q  <= 1'b0;
    end else begin
      run_cnt_q   <= run_cnt_d;
      enc_valid_q <= enc_valid_d;
      enc_data_q  <= enc_data_d;
      nnz_acc_q   <= nnz_acc_d;
      rec_nnz_q   <= rec_nnz_d;
      nnz_cnt_q   <= nnz_cnt_d;
      vec_done_q  <= vec_done_d;
    end
  end

  assign enc_valid_o = enc_valid_q;
  assign enc_data_o  = enc_data_q;
  assign nnz_cnt_o   = nnz_cnt_q;
  assign vec_done_o  = vec_done_q;

endmodule : sparse_encoder

// File: tb/tb_sparse_encoder.sv
// Directed, table-driven bench for sparse_encoder with hand-computed records.
module tb_sparse_encoder;
  import sparse_mac_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic               mac_clk;
  logic               mac_rst;
  logic               dense_valid_i;
  logic               dense_ready_o;
  logic [VALUE_W-1:0] dense_value_i;
  logic               dense_last_i;
  logic               enc_valid_o;
  logic               enc_ready_i;
  sram_data_t         enc_data_o;
  logic [CNT_W-1:0]   nnz_cnt_o;
  logic               vec_done_o;

  sparse_encoder #(.CNT_W(CNT_W)) dut (
    .mac_clk       (mac_clk),
    .mac_rst       (mac_rst),
    .dense_valid_i (dense_valid_i),
    .dense_ready_o (dense_ready_o),
    .dense_value_i (dense_value_i),
    .dense_last_i  (dense_last_i),
    .enc_valid_o   (enc_valid_o),
    .enc_ready_i   (enc_ready_i),
    .enc_data_o    (enc_data_o),
    .nnz_cnt_o     (nnz_cnt_o),
    .vec_done_o    (vec_done_o)
  );

  initial mac_clk = 1'b0;
  always #5 mac_clk = ~mac_clk;

  // One row = inputs for one clock edge and the outputs expected after it.
  typedef struct {
    logic        v;
    logic [7:0]  val;
    logic        last;
    logic        rdy;
    logic        ev;
    sram_data_t  d;
    logic        vd;
    logic [15:0] nnz;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(logic v, logic [7:0] val, logic last, logic rdy, logic ev,
                              logic [3:0] skip, logic [7:0] rval, logic rdone,
                              logic vd, logic [15:0] nnz);
    vec_t r;
    r.v = v; r.val = val; r.last = last; r.rdy = rdy; r.ev = ev;
    r.d = '{skip: skip, value: rval, done: rdone};
    r.vd = vd; r.nnz = nnz;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] val, input logic last, input logic rdy);
    dense_valid_i = v;
    dense_value_i = val;
    dense_last_i  = last;
    enc_ready_i   = rdy;
  endtask

  task automatic step();
    @(posedge mac_clk);
    #1;
  endtask

  task automatic chk_rec(input string name, input logic [3:0] skip, input logic [7:0] val,
                         input logic done);
    sram_data_t e;
    e = '{skip: skip, value: val, done: done};
    chk({name, ".valid"}, 32'(enc_valid_o), 32'd1);
    chk({name, ".data"}, 32'(enc_data_o), 32'(e));
  endtask

  initial begin
    // Vector A: [0,0,0,5,0,0,0,0,0,0,4L] -> (3,5,0),(6,4,1)
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 5, 0, 1, 1, 3, 5, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4, 1, 1, 1, 6, 4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 2);
    // Vector B: 20 zeros -> (15,0,0),(3,0,1), nnz 0
    for (int i = 0; i < 15; i++) add(1, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 1, 1, 15, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    add(1, 0, 1, 1, 1, 3, 0, 1, 0, 2);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // Vector C: 1..8 continuous, done on 8
    for (int i = 1; i <= 8; i++)
      add(1, 8'(i), (i == 8), 1, 1, 0, 8'(i), (i == 8), 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 8);
    // Vectors D/E back to back: [7L] then [0,9L]
    add(1, 7, 1, 1, 1, 0, 7, 1, 0, 8);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    add(1, 9, 1, 1, 1, 1, 9, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

    drive(0, 0, 0, 1);
    mac_rst = 1'b0;
    #12;
    chk("rst.valid", 32'(enc_valid_o), 32'd0);
    chk("rst.data", 32'(enc_data_o), 32'd0);
    chk("rst.nnz", 32'(nnz_cnt_o), 32'd0);
    chk("rst.vec_done", 32'(vec_done_o), 32'd0);
    chk("rst.ready", 32'(dense_ready_o), 32'd1);
    @(negedge mac_clk);
    mac_rst = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].val, tbl[i].last, tbl[i].rdy);
      step();
      chk($sformatf("row%0d.valid", i), 32'(enc_valid_o), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("row%0d.data", i), 32'(enc_data_o), 32'(tbl[i].d));
      chk($sformatf("row%0d.vec_done", i), 32'(vec_done_o), 32'(tbl[i].vd));
      chk($sformatf("row%0d.nnz", i), 32'(nnz_cnt_o), 32'(tbl[i].nnz));
    end

    // Backpressure: (2,6,0) pending while 3L waits for three stalled cycles
    drive(1, 0, 0, 1); step();
    drive(1, 0, 0, 1); step();
    drive(1, 6, 0, 1); step();
    chk_rec("stall.load", 2, 6, 0);
    for (int c = 0; c < 3; c++) begin
      drive(1, 3, 1, 0);
      #1;
      chk($sformatf("stall%0d.ready", c), 32'(dense_ready_o), 32'd0);
      step();
      chk_rec($sformatf("stall%0d", c), 2, 6, 0);
    end
    drive(1, 3, 1, 1);
    #1;
    chk("stall.release_ready", 32'(dense_ready_o), 32'd1);
    step();
    chk_rec("stall.next", 0, 3, 1);
    drive(0, 0, 0, 1); step();
    chk("stall.vec_done", 32'(vec_done_o), 32'd1);
    chk("stall.nnz", 32'(nnz_cnt_o), 32'd2);
    chk("stall.idle_valid", 32'(enc_valid_o), 32'd0);

    // Reset mid-vector after 5 zeros discards the partial run
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, 1); step();
    end
    drive(0, 0, 0, 1);
    mac_rst = 1'b0;
    #2;
    chk("midrst.valid", 32'(enc_valid_o), 32'd0);
    chk("midrst.nnz", 32'(nnz_cnt_o), 32'd0);
    @(negedge mac_clk);
    mac_rst = 1'b1;
    drive(1, 3, 1, 1); step();
    chk_rec("midrst.rec", 0, 3, 1);
    drive(0, 0, 0, 1); step();
    chk("midrst.vec_done", 32'(vec_done_o), 32'd1);
    chk("midrst.nnz_after", 32'(nnz_cnt_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sparse_encoder

// File: doc/sparse_encoder.md
Name: sparse_encoder

Overview:
Compresses a dense value stream into the run-length (skip, value, done) records consumed by the sparse MAC decoder path. Each record carries the zero count that precedes a value. Sits upstream of the SRAM writer: a dense vector producer feeds it, and its record output lands in SRAM as sram_data_t words. It is the exact inverse of the decoder's index accumulation, which computes index = prev_index + skip + 1 with a reset value of all-ones.

Parameters:
VALUE_W, 8, width of one dense element / record value (package constant)
SKIP_W, 4, width of record skip field; SKIP_MAX = 2^SKIP_W-1 (package constant)
CNT_W, 16, width of per-vector nonzero statistics counter

Ports:
mac_clk  in  1  clock
mac_rst  in  1  reset, asynchronous, active-low
dense_valid_i  in  1  dense element valid
dense_ready_o  out  1  dense element accept
dense_value_i  in  VALUE_W  dense element value
dense_last_i  in  1  final element of current vector
enc_valid_o  out  1  record valid
enc_ready_i  in  1  downstream (SRAM writer) accept
enc_data_o  out  $bits(sram_data_t)  record {skip, value, done}
nnz_cnt_o  out  CNT_W  nonzero count of last completed vector
vec_done_o  out  1  one-cycle pulse when the done record is accepted downstream

Behaviour:
- Reset (async, mac_rst=0): run_cnt=0, enc_valid_o=0, enc_data_o=0, nnz_acc=0, nnz_cnt_o=0, vec_done_o=0.
- Handshakes: accept = dense_valid_i & dense_ready_o; emit = enc_valid_o & enc_ready_i.
- dense_ready_o = ~enc_valid_o | enc_ready_i. This is a single registered output stage with full throughput (1 element/cycle) and zero bubbles under continuous ready.
- enc_data_o holds stable while enc_valid_o=1 and enc_ready_i=0. No record is ever dropped or duplicated.
- run_cnt[SKIP_W-1:0] counts zeros seen since the last emitted record. On accept, exactly one case applies, in priority order:
  1. value!=0: load record {skip=run_cnt, value, done=last}; run_cnt<=0; nnz_acc+=1.
  2. value==0 and last: load {skip=run_cnt, value=0, done=1}; run_cnt<=0. This terminal explicit-zero record keeps vector length exact.
  3. value==0, not last, run_cnt==SKIP_MAX: load {skip=SKIP_MAX, value=0, done=0}; run_cnt<=0. The record covers SKIP_MAX+1 positions.
  4. Otherwise: run_cnt<=run_cnt+1; no record; enc_valid_o<=0 if emit occurred this cycle.
- Output register update:
  - If a record is loaded, enc_valid_o<=1.
  - Else if emit, enc_valid_o<=0.
  - Latency: accept at edge N, enc_valid_o=1 after edge N (visible in cycle N+1).
- Simultaneous emit and accept: the new record replaces the old in the same edge, and enc_valid_o stays 1.
- run_cnt never wraps; case 3 guarantees run_cnt<=SKIP_MAX.
- Statistics:
  - When the done record is accepted on the input side, nnz_acc clears to 0 for the next vector. The completed count (including that element if nonzero) is held with the record.
  - nnz_cnt_o updates and vec_done_o pulses on the cycle the done record is emitted downstream.
  - nnz_acc saturates at 2^CNT_W-1.
- Back-to-back vectors: the next vector's first element is accepted in the cycle after its predecessor's last element. State is fully reset by the done record, with no idle cycle required.
- dense_valid_i low: no state change, and the partial zero run is preserved indefinitely.
- Reset mid-vector: partial run and pending record are discarded. The first element after reset starts a new vector.

Decomposition:
- sparse_mac_pkg holds: VALUE_W, SKIP_W, SKIP_MAX, and sram_data_t {skip[SKIP_W], value[VALUE_W], done}. This is the same typedef the decoder consumes, so the encoder and decoder cannot drift.
- Single module, with no sub-module. The output stage is the one-entry register described above.
- Downstream decoupling is left to the SRAM writer's existing skid_buffer.

Test Plan:
- Stream [0,0,0,5,0,0,0,0,0,0,4(last)], ready=1 -> records (3,5,0),(6,4,1); nnz_cnt_o=2; vec_done_o one pulse. A decoder fed these records gives indices 3 and 10.
- 20 zeros, last on 20th -> (15,0,0),(3,0,1); nnz_cnt_o=0; total positions 16+4=20.
- Single element 7(last) -> (0,7,1) one cycle after accept; then [0,9(last)] next cycle -> (1,9,1) with no idle gap.
- enc_ready_i=0 for 3 cycles while record (2,6,0) is pending and input valid -> dense_ready_o=0, enc_data_o stable for all 3 cycles, next record follows with no loss.
- Continuous nonzero stream 1..8 (last on 8), ready=1 -> 8 records skip=0, one per cycle, done only on value 8, nnz_cnt_o=8.
- Assert mac_rst after 5 zeros mid-vector, then stream [3(last)] -> single record (0,3,1); no stale skip.
